// File: rtl/id_ex_reg_if.sv
// Decode-to-execute bundle for the ID/EX pipeline register.
// The master modport drives the ID side and the slave modport is the register itself.
interface id_ex_reg_if #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned ADDR_W = 5
) ();
  logic [31:0]       immExtD;
  logic [31:0]       rsDataD;
  logic [31:0]       rtDataD;
  logic [ADDR_W-1:0] rsAddrD;
  logic [ADDR_W-1:0] rtAddrD;
  logic [ADDR_W-1:0] rdAddrD;
  logic              useRsD;
  logic              useRtD;
  logic [31:0]       pcPlus4D;
  logic [CTRL_W-1:0] ctrlD;
  logic              validD;
  logic              holdE;
  logic              flush;

  logic [31:0]       immExtE;
  logic [31:0]       rsDataE;
  logic [31:0]       rtDataE;
  logic [ADDR_W-1:0] rsAddrE;
  logic [ADDR_W-1:0] rtAddrE;
  logic [ADDR_W-1:0] rdAddrE;
  logic [31:0]       pcPlus4E;
  logic [CTRL_W-1:0] ctrlE;
  logic              validE;
  logic              loadUseStall;

  modport master (
    output immExtD, rsDataD, rtDataD, rsAddrD, rtAddrD, rdAddrD, useRsD, useRtD,
           pcPlus4D, ctrlD, validD, holdE, flush,
    input  immExtE, rsDataE, rtDataE, rsAddrE, rtAddrE, rdAddrE, pcPlus4E, ctrlE,
           validE, loadUseStall
  );

  modport slave (
    input  immExtD, rsDataD, rtDataD, rsAddrD, rtAddrD, rdAddrD, useRsD, useRtD,
           pcPlus4D, ctrlD, validD, holdE, flush,
    output immExtE, rsDataE, rtDataE, rsAddrE, rtAddrE, rdAddrE, pcPlus4E, ctrlE,
           validE, loadUseStall
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection, downstream hold and flush.
// A bubble zeroes the whole E bundle so forwarding never matches on stale indices.
module id_ex_reg #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned ADDR_W = 5
) (
  input logic        clk,
  input logic        rst,
  id_ex_reg_if.slave bus
);

  typedef struct packed {
    logic [31:0]       imm;
    logic [31:0]       rs_data;
    logic [31:0]       rt_data;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       pc_plus4;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
  } stage_t;

  stage_t e_q, e_d, d_bundle;
  logic   rs_hit, rt_hit, load_use;

  assign d_bundle = '{
    imm:      bus.immExtD,
    rs_data:  bus.rsDataD,
    rt_data:  bus.rtDataD,
    rs_addr:  bus.rsAddrD,
    rt_addr:  bus.rtAddrD,
    rd_addr:  bus.rdAddrD,
    pc_plus4: bus.pcPlus4D,
    ctrl:     bus.ctrlD,
    valid:    bus.validD
  };

  // ctrl bit 0 marks a load; its rt is the destination the ID instruction may need.
  assign rs_hit   = bus.useRsD && (bus.rsAddrD == e_q.rt_addr);
  assign rt_hit   = bus.useRtD && (bus.rtAddrD == e_q.rt_addr);
  assign load_use = e_q.valid && e_q.ctrl[0] && bus.validD && (e_q.rt_addr != '0) &&
                    (rs_hit || rt_hit);

  always_comb begin
    e_d = e_q;
    if (bus.holdE) begin
      e_d = e_q;
    end else if (bus.flush || load_use) begin
      e_d = '0;
    end else begin
      e_d = d_bundle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= '0;
    end else begin
      e_q <= e_d;
    end
  end

  assign bus.immExtE      = e_q.imm;
  assign bus.rsDataE      = e_q.rs_data;
  assign bus.rtDataE      = e_q.rt_data;
  assign bus.rsAddrE      = e_q.rs_addr;
  assign bus.rtAddrE      = e_q.rt_addr;
  assign bus.rdAddrE      = e_q.rd_addr;
  assign bus.pcPlus4E     = e_q.pc_plus4;
  assign bus.ctrlE        = e_q.ctrl;
  assign bus.validE       = e_q.valid;
  assign bus.loadUseStall = load_use;

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomised self-checking bench for id_ex_reg against a behavioural model of the E stage.
module tb_id_ex_reg;

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rsa;
    logic [4:0]  rta;
    logic [4:0]  rda;
    logic [31:0] pc;
    logic [15:0] ctrl;
    logic        v;
  } ebundle_t;

  logic     clk;
  logic     rst;
  int       n_checks;
  int       n_pass;
  ebundle_t model;

  id_ex_reg_if #(.CTRL_W(16), .ADDR_W(5)) bus ();

  id_ex_reg #(.CTRL_W(16), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ebundle_t dut_e();
    return {bus.immExtE, bus.rsDataE, bus.rtDataE, bus.rsAddrE, bus.rtAddrE, bus.rdAddrE,
            bus.pcPlus4E, bus.ctrlE, bus.validE};
  endfunction

  function automatic ebundle_t d_now();
    return {bus.immExtD, bus.rsDataD, bus.rtDataD, bus.rsAddrD, bus.rtAddrD, bus.rdAddrD,
            bus.pcPlus4D, bus.ctrlD, bus.validD};
  endfunction

  // A load in EX whose destination is a nonzero register the ID instruction reads.
  function automatic bit model_stall();
    return model.v && model.ctrl[0] && bus.validD && (model.rta != 5'd0) &&
           ((bus.useRsD && bus.rsAddrD == model.rta) || (bus.useRtD && bus.rtAddrD == model.rta));
  endfunction

  task automatic set_d(input logic [4:0] rsa, input logic [4:0] rta, input logic [4:0] rda,
                       input logic urs, input logic urt, input logic [15:0] ctrl, input logic v);
    bus.immExtD  = $urandom;
    bus.rsDataD  = $urandom;
    bus.rtDataD  = $urandom;
    bus.pcPlus4D = $urandom;
    bus.rsAddrD  = rsa;
    bus.rtAddrD  = rta;
    bus.rdAddrD  = rda;
    bus.useRsD   = urs;
    bus.useRtD   = urt;
    bus.ctrlD    = v ? ctrl : 16'h0;
    bus.validD   = v;
  endtask

  task automatic tick();
    ebundle_t nxt;
    if (rst) nxt = '0;
    else if (bus.holdE) nxt = model;
    else if (bus.flush || model_stall()) nxt = '0;
    else nxt = d_now();
    @(posedge clk);
    #1;
    model = nxt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.holdE = 1'b0;
    bus.flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_d(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 16'($urandom), 1'b1);
      tick();
      n_checks++;
      if (dut_e() !== 160'h0) $display("FAIL reset_e got=%h exp=0", dut_e());
      else n_pass++;
      n_checks++;
      if (bus.loadUseStall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", bus.loadUseStall);
      else n_pass++;
    end
    rst = 1'b0;
    set_d(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 16'h0, 1'b1);
    bus.immExtD = 32'hFFFF8000;
    tick();
    n_checks++;
    if (bus.immExtE !== 32'hFFFF8000 || bus.validE !== 1'b1)
      $display("FAIL reset_release got imm=%h v=%b exp imm=ffff8000 v=1", bus.immExtE, bus.validE);
    else n_pass++;
  endtask

  task automatic test_passthrough();
    logic [31:0] imms [4];
    logic [31:0] pc;
    imms[0] = 32'h00001234;
    imms[1] = 32'h12340000;
    imms[2] = 32'hFFFFFFFF;
    imms[3] = 32'h00000000;
    for (int i = 0; i < 4; i++) begin
      set_d(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 16'($urandom) & 16'hFFFE,
            1'b1);
      bus.immExtD  = imms[i];
      pc           = 32'h0040_0000 + 32'(4 * (i + 1));
      bus.pcPlus4D = pc;
      tick();
      n_checks++;
      if (bus.immExtE !== imms[i] || bus.pcPlus4E !== pc || dut_e() !== model)
        $display("FAIL pass_%0d got imm=%h pc=%h e=%h exp imm=%h pc=%h e=%h", i, bus.immExtE,
                 bus.pcPlus4E, dut_e(), imms[i], pc, model);
      else n_pass++;
    end
  endtask

  task automatic test_load_use();
    // Load writing $8, then a consumer of $8.
    set_d(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 16'h0001, 1'b1);
    tick();
    set_d(5'd8, 5'd2, 5'd9, 1'b1, 1'b0, 16'h0002, 1'b1);
    #1;
    n_checks++;
    if (bus.loadUseStall !== 1'b1) $display("FAIL lu_stall got=%b exp=1", bus.loadUseStall);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.validE !== 1'b0 || bus.ctrlE !== 16'h0 || dut_e() !== model)
      $display("FAIL lu_bubble got v=%b ctrl=%h e=%h exp v=0 ctrl=0 e=%h", bus.validE,
               bus.ctrlE, dut_e(), model);
    else n_pass++;
    n_checks++;
    if (bus.loadUseStall !== 1'b0) $display("FAIL lu_release got=%b exp=0", bus.loadUseStall);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.validE !== 1'b1 || bus.rsAddrE !== 5'd8 || dut_e() !== model)
      $display("FAIL lu_enter got v=%b rs=%0d e=%h exp v=1 rs=8 e=%h", bus.validE,
               bus.rsAddrE, dut_e(), model);
    else n_pass++;

    // Load to $0 never stalls.
    set_d(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 16'h0001, 1'b1);
    tick();
    set_d(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 16'h0002, 1'b1);
    #1;
    n_checks++;
    if (bus.loadUseStall !== 1'b0) $display("FAIL lu_zero got=%b exp=0", bus.loadUseStall);
    else n_pass++;
    tick();

    // rs matches but is unused, rt is used and differs.
    set_d(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 16'h0001, 1'b1);
    tick();
    set_d(5'd8, 5'd3, 5'd5, 1'b0, 1'b1, 16'h0002, 1'b1);
    #1;
    n_checks++;
    if (bus.loadUseStall !== 1'b0) $display("FAIL lu_unused got=%b exp=0", bus.loadUseStall);
    else n_pass++;
    tick();

    // Non-load in EX writing $3 (which is in rtAddrE now).
    set_d(5'd3, 5'd3, 5'd6, 1'b1, 1'b1, 16'h0002, 1'b1);
    #1;
    n_checks++;
    if (bus.loadUseStall !== 1'b0) $display("FAIL lu_nonload got=%b exp=0", bus.loadUseStall);
    else n_pass++;
    tick();

    // Invalid ID slot never stalls and loads as a bubble.
    set_d(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 16'h0001, 1'b1);
    tick();
    set_d(5'd8, 5'd8, 5'd7, 1'b1, 1'b1, 16'h0000, 1'b0);
    #1;
    n_checks++;
    if (bus.loadUseStall !== 1'b0) $display("FAIL lu_invalid got=%b exp=0", bus.loadUseStall);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.validE !== 1'b0 || bus.ctrlE !== 16'h0 || dut_e() !== model)
      $display("FAIL lu_invalid_e got=%h exp=%h", dut_e(), model);
    else n_pass++;
  endtask

  task automatic test_flush();
    set_d(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 16'h00F2, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_checks++;
    if (bus.validE !== 1'b0 || bus.ctrlE !== 16'h0 || dut_e() !== model)
      $display("FAIL flush got v=%b ctrl=%h exp v=0 ctrl=0", bus.validE, bus.ctrlE);
    else n_pass++;

    // Flush coinciding with a load-use stall yields one bubble only.
    set_d(5'd1, 5'd9, 5'd0, 1'b1, 1'b0, 16'h0001, 1'b1);
    tick();
    set_d(5'd9, 5'd2, 5'd4, 1'b1, 1'b0, 16'h0004, 1'b1);
    bus.flush = 1'b1;
    #1;
    n_checks++;
    if (bus.loadUseStall !== 1'b1) $display("FAIL flush_stall got=%b exp=1", bus.loadUseStall);
    else n_pass++;
    tick();
    bus.flush = 1'b0;
    n_checks++;
    if (bus.validE !== 1'b0 || bus.loadUseStall !== 1'b0)
      $display("FAIL flush_lu_bubble got v=%b stall=%b exp v=0 stall=0", bus.validE,
               bus.loadUseStall);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.validE !== 1'b1 || dut_e() !== model)
      $display("FAIL flush_lu_after got v=%b e=%h exp v=1 e=%h", bus.validE, dut_e(), model);
    else n_pass++;
  endtask

  task automatic test_hold();
    ebundle_t snap;
    set_d(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 16'h0AB0, 1'b1);
    tick();
    snap = dut_e();
    bus.holdE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_d(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 16'($urandom), 1'b1);
      bus.flush = i[0];
      tick();
      n_checks++;
      if (dut_e() !== snap || dut_e() !== model)
        $display("FAIL hold_%0d got=%h exp=%h", i, dut_e(), model);
      else n_pass++;
    end
    bus.holdE = 1'b0;
    bus.flush = 1'b0;
    set_d(5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 16'h0C00, 1'b1);
    snap = d_now();
    tick();
    n_checks++;
    if (dut_e() !== snap) $display("FAIL hold_release got=%h exp=%h", dut_e(), snap);
    else n_pass++;
  endtask

  task automatic test_hold_hazard();
    ebundle_t snap;
    set_d(5'd1, 5'd10, 5'd0, 1'b1, 1'b0, 16'h0001, 1'b1);
    tick();
    snap = dut_e();
    set_d(5'd3, 5'd10, 5'd11, 1'b0, 1'b1, 16'h0008, 1'b1);
    bus.holdE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (bus.loadUseStall !== 1'b1) $display("FAIL hh_stall_%0d got=%b exp=1", i,
                                              bus.loadUseStall);
      else n_pass++;
      tick();
      n_checks++;
      if (dut_e() !== snap) $display("FAIL hh_hold_%0d got=%h exp=%h", i, dut_e(), snap);
      else n_pass++;
    end
    bus.holdE = 1'b0;
    tick();
    n_checks++;
    if (bus.validE !== 1'b0 || dut_e() !== model)
      $display("FAIL hh_bubble got=%h exp=%h", dut_e(), model);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.validE !== 1'b1 || bus.rdAddrE !== 5'd11 || dut_e() !== model)
      $display("FAIL hh_enter got=%h exp=%h", dut_e(), model);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    logic v;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 31) == 0);
      bus.holdE = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 5) == 0);
      v         = ($urandom_range(0, 4) != 0);
      set_d(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 16'($urandom), v);
      #1;
      if (bus.loadUseStall !== model_stall() && errs < 5) begin
        errs++;
        $display("FAIL rand_stall_%0d got=%b exp=%b", i, bus.loadUseStall, model_stall());
      end
      tick();
      if (dut_e() !== model && errs < 5) begin
        errs++;
        $display("FAIL rand_e_%0d got=%h exp=%h", i, dut_e(), model);
      end
    end
    rst = 1'b0;
    bus.holdE = 1'b0;
    bus.flush = 1'b0;
    n_checks++;
    if (errs == 0) n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model    = '0;
    rst      = 1'b1;
    test_reset();
    test_passthrough();
    test_load_use();
    test_flush();
    test_hold();
    test_hold_hazard();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
